// File: rtl/commit_store_buffer.sv
// commit_store_buffer
// Queue of committed stores that drains, one at a time, into the L1 data
// cache store port using the two-phase request: the index, data, byte
// enables and size go out first. After the grant, the tag goes out on the
// following cycle and the head entry is popped. The block also reports
// whether any pending store overlaps the doubleword of a load's page offset.
//
// Optional feature: define COMMIT_SB_OFFSET_CHECK_EN to build the page-offset
// comparators. Without it, page_offset_matches_o is tied low and the load
// unit orders itself on empty_o.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   valid_i / ready_o      commit push handshake (push = valid_i && ready_o)
//   paddr_i, data_i,
//   be_i, data_size_i      store payload captured on push
//   req_port_i             cache response (only data_gnt is used)
//   req_port_o             cache request (index phase, then tag phase)
//   page_offset_i          load page offset to compare against
//   page_offset_matches_o  some pending store hits the load's doubleword
//   empty_o                nothing buffered and nothing in flight

package commit_sb_pkg;
   localparam int unsigned DCACHE_INDEX_WIDTH = 12;
   localparam int unsigned DCACHE_TAG_WIDTH   = 44;

   typedef struct packed {
      logic [DCACHE_INDEX_WIDTH-1:0] address_index;
      logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
      logic [63:0]                   data_wdata;
      logic                          data_req;
      logic                          data_we;
      logic [7:0]                    data_be;
      logic [1:0]                    data_size;
      logic                          kill_req;
      logic                          tag_valid;
   } dcache_req_i_t;

   typedef struct packed {
      logic        data_gnt;
      logic        data_rvalid;
      logic [63:0] data_rdata;
   } dcache_req_o_t;
endpackage

// Protocol checker: a push offered while the buffer is full is dropped by
// the buffer; this flags it. The sticky flag is kept for observation, the
// assertion can be disabled for benches that provoke the condition on purpose.
module commit_store_buffer_chk #(
   parameter bit ASSERT_EN = 1'b1
) (
   input logic clk_i,
   input logic rst_ni,
   input logic valid_i,
   input logic ready_o
);
   logic overflow_seen_q;

   // sticky record of any push attempted while full
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         overflow_seen_q <= 1'b0;
      end else begin
         overflow_seen_q <= overflow_seen_q | (valid_i & ~ready_o);
      end
   end

   if (ASSERT_EN) begin : g_assert
      a_no_push_when_full: assert property (
         @(posedge clk_i) disable iff (!rst_ni) !(valid_i && !ready_o)
      ) else $error("commit_store_buffer: push offered while full was dropped");
   end
endmodule

module commit_store_buffer
   import commit_sb_pkg::*;
#(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned INDEX_WIDTH = 12,
   parameter int unsigned TAG_WIDTH   = 44,
   parameter bit          ASSERT_EN   = 1'b1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          valid_i,
   output logic          ready_o,
   input  logic [55:0]   paddr_i,
   input  logic [63:0]   data_i,
   input  logic [7:0]    be_i,
   input  logic [1:0]    data_size_i,
   input  dcache_req_o_t req_port_i,
   output dcache_req_i_t req_port_o,
   input  logic [11:0]   page_offset_i,
   output logic          page_offset_matches_o,
   output logic          empty_o
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W+1)'(0);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_SEND_TAG = 1'b1
   } state_e;

   logic [55:0] paddr_q [DEPTH];
   logic [63:0] data_q  [DEPTH];
   logic [7:0]  be_q    [DEPTH];
   logic [1:0]  size_q  [DEPTH];

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   cnt_q, cnt_d;
   state_e           state_q, state_d;

   logic push_s;
   logic pop_s;
   logic match_s;

   // Room is judged on the registered count only: a pop in the same cycle
   // does not free a slot for a push until the next cycle.
   assign ready_o = (cnt_q != CNT_FULL);
   assign empty_o = (cnt_q == CNT_ZERO) && (state_q == ST_IDLE);
   assign push_s  = valid_i && ready_o;
   assign pop_s   = (state_q == ST_SEND_TAG);

   // next-state for pointers, occupancy count and drain FSM
   always_comb begin
      rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;

      case ({push_s, pop_s})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase

      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if ((cnt_q != CNT_ZERO) && req_port_i.data_gnt) begin
               state_d = ST_SEND_TAG;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND_TAG: state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // control state registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         state_q  <= ST_IDLE;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
      end
   end

   // entry storage, written at the tail on an accepted push
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            paddr_q[i] <= 56'd0;
            data_q[i]  <= 64'd0;
            be_q[i]    <= 8'd0;
            size_q[i]  <= 2'd0;
         end
      end else if (push_s) begin
         paddr_q[wr_ptr_q] <= paddr_i;
         data_q[wr_ptr_q]  <= data_i;
         be_q[wr_ptr_q]    <= be_i;
         size_q[wr_ptr_q]  <= data_size_i;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            paddr_q[i] <= paddr_q[i];
            data_q[i]  <= data_q[i];
            be_q[i]    <= be_q[i];
            size_q[i]  <= size_q[i];
         end
      end
   end

   // cache request decoded from registered state only; the head entry is
   // held unchanged until the tag phase pops it, so the request is stable
   // while waiting for a grant
   always_comb begin
      req_port_o          = '0;
      req_port_o.data_we  = 1'b1;
      req_port_o.kill_req = 1'b0;
      if (state_q == ST_SEND_TAG) begin
         req_port_o.tag_valid     = 1'b1;
         req_port_o.address_tag   = paddr_q[rd_ptr_q][INDEX_WIDTH+TAG_WIDTH-1:INDEX_WIDTH];
         req_port_o.address_index = paddr_q[rd_ptr_q][INDEX_WIDTH-1:0];
         req_port_o.data_wdata    = data_q[rd_ptr_q];
         req_port_o.data_be       = be_q[rd_ptr_q];
         req_port_o.data_size     = size_q[rd_ptr_q];
      end else if (cnt_q != CNT_ZERO) begin
         req_port_o.data_req      = 1'b1;
         req_port_o.address_index = paddr_q[rd_ptr_q][INDEX_WIDTH-1:0];
         req_port_o.data_wdata    = data_q[rd_ptr_q];
         req_port_o.data_be       = be_q[rd_ptr_q];
         req_port_o.data_size     = size_q[rd_ptr_q];
      end else begin
         req_port_o.data_req      = 1'b0;
      end
   end

`ifdef COMMIT_SB_OFFSET_CHECK_EN
   logic [PTR_W-1:0] rel_s;
   logic             unused_s;

   // A slot is occupied when its distance from the head is below the count;
   // the head stays occupied through the tag phase until it is popped.
   always_comb begin
      match_s = 1'b0;
      rel_s   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         rel_s = PTR_W'(i) - rd_ptr_q;
         if (({1'b0, rel_s} < cnt_q) && (paddr_q[i][11:3] == page_offset_i[11:3])) begin
            match_s = 1'b1;
         end else begin
            match_s = match_s;
         end
      end
   end

   assign unused_s = ^{req_port_i.data_rvalid, req_port_i.data_rdata, page_offset_i[2:0]};
`else
   logic unused_s;

   assign match_s  = 1'b0;
   assign unused_s = ^{req_port_i.data_rvalid, req_port_i.data_rdata, page_offset_i};
`endif

   assign page_offset_matches_o = match_s;

   commit_store_buffer_chk #(
      .ASSERT_EN (ASSERT_EN)
   ) u_chk (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (valid_i),
      .ready_o (ready_o)
   );
endmodule

// File: tb/tb_commit_store_buffer.sv
module tb_commit_store_buffer;
   import commit_sb_pkg::*;

   localparam int DEPTH = 4;
`ifdef COMMIT_SB_OFFSET_CHECK_EN
   localparam bit OFFS_EN = 1'b1;
`else
   localparam bit OFFS_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_ni;
   logic          valid;
   logic          ready_o;
   logic [55:0]   paddr;
   logic [63:0]   data;
   logic [7:0]    be;
   logic [1:0]    size;
   dcache_req_o_t req_in;
   dcache_req_i_t req_out;
   logic [11:0]   po;
   logic          match_o;
   logic          empty_o;

   always #5 clk = ~clk;

   commit_store_buffer #(
      .DEPTH(DEPTH), .INDEX_WIDTH(12), .TAG_WIDTH(44), .ASSERT_EN(1'b0)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid), .ready_o(ready_o),
      .paddr_i(paddr), .data_i(data), .be_i(be), .data_size_i(size),
      .req_port_i(req_in), .req_port_o(req_out), .page_offset_i(po),
      .page_offset_matches_o(match_o), .empty_o(empty_o)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model: a queue of pending stores ----------
   typedef struct {
      logic [55:0] paddr;
      logic [63:0] data;
      logic [7:0]  be;
      logic [1:0]  size;
   } ent_t;

   ent_t mq[$];
   bit   m_sent;   // head has been granted; its tag goes out this cycle

   task automatic check_model(string tag);
      bit exp_req;
      bit exp_match;
      exp_req   = !m_sent && (mq.size() > 0);
      exp_match = 1'b0;
      foreach (mq[i]) if (mq[i].paddr[11:3] == po[11:3]) exp_match = OFFS_EN;
      chk({tag, ".ready"}, 64'(ready_o), 64'(mq.size() != DEPTH));
      chk({tag, ".req"},   64'(req_out.data_req), 64'(exp_req));
      chk({tag, ".tv"},    64'(req_out.tag_valid), 64'(m_sent));
      chk({tag, ".empty"}, 64'(empty_o), 64'(mq.size() == 0 && !m_sent));
      chk({tag, ".we"},    64'(req_out.data_we), 64'd1);
      chk({tag, ".kill"},  64'(req_out.kill_req), 64'd0);
      chk({tag, ".match"}, 64'(match_o), 64'(exp_match));
      if (exp_req) begin
         chk({tag, ".idx"},   64'(req_out.address_index), 64'(mq[0].paddr[11:0]));
         chk({tag, ".wdata"}, req_out.data_wdata, mq[0].data);
         chk({tag, ".be"},    64'(req_out.data_be), 64'(mq[0].be));
         chk({tag, ".size"},  64'(req_out.data_size), 64'(mq[0].size));
      end
      if (m_sent) begin
         chk({tag, ".tag"}, 64'(req_out.address_tag), 64'(mq[0].paddr[55:12]));
      end
   endtask

   // one clock: apply inputs, check against the model, advance the model
   task automatic mcycle(string tag, bit v, ent_t e, bit g, logic [11:0] off);
      bit was_req;
      bit push;
      valid = v; paddr = e.paddr; data = e.data; be = e.be; size = e.size;
      req_in.data_gnt    = g;
      req_in.data_rvalid = 1'($urandom_range(0, 1));
      req_in.data_rdata  = {$urandom, $urandom};
      po = off;
      #1;
      check_model(tag);
      was_req = !m_sent && (mq.size() > 0);
      push    = v && (mq.size() != DEPTH);
      if (push) mq.push_back(e);
      if (m_sent) begin
         void'(mq.pop_front());
         m_sent = 1'b0;
      end else if (was_req && g) begin
         m_sent = 1'b1;
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_ni = 1'b0; valid = 1'b0; req_in = '0; po = 12'd0;
      mq.delete(); m_sent = 1'b0;
      @(negedge clk);
      rst_ni = 1'b1;
      @(posedge clk); #1;
   endtask

   function automatic ent_t mk(logic [55:0] pa, logic [63:0] d, logic [7:0] b, logic [1:0] s);
      ent_t e;
      e.paddr = pa; e.data = d; e.be = b; e.size = s;
      return e;
   endfunction

   function automatic logic [55:0] pk(int k);
      return 56'h0000_0ABC_D000 + 56'(k) * 56'h0000_0001_0048;
   endfunction

   function automatic logic [63:0] dk(int k);
      return 64'h0123_4567_0000_0000 + 64'(k);
   endfunction

   // ---------------- directed vector table -------------------------------
   typedef struct {
      bit          v;
      logic [55:0] pa;
      logic [63:0] d;
      bit          g;
      bit          e_rdy, e_req, e_tv, e_emp;
      logic [55:0] e_pa;
      logic [63:0] e_d;
   } vec_t;

   vec_t vt[$];

   function automatic void addv(bit v, logic [55:0] pa, logic [63:0] d, bit g,
                                bit rdy, bit rq, bit tv, bit emp,
                                logic [55:0] epa, logic [63:0] ed);
      vec_t r;
      r.v = v; r.pa = pa; r.d = d; r.g = g;
      r.e_rdy = rdy; r.e_req = rq; r.e_tv = tv; r.e_emp = emp;
      r.e_pa = epa; r.e_d = ed;
      vt.push_back(r);
   endfunction

   initial begin
      logic [55:0] s_pa;
      logic [63:0] s_d;
      ent_t        e;
      int          pushed, ntag, last_tag;

      s_pa = 56'h0000_0000_8000_1238;
      s_d  = 64'h0000_0000_DEAD_BEEF;
      // single store, grant after 3 waiting cycles
      addv(1, s_pa, s_d, 0,   1, 0, 0, 1,   56'd0, 64'd0);
      addv(0, 56'd0, 64'd0, 0, 1, 1, 0, 0,  s_pa, s_d);
      addv(0, 56'd0, 64'd0, 0, 1, 1, 0, 0,  s_pa, s_d);
      addv(0, 56'd0, 64'd0, 0, 1, 1, 0, 0,  s_pa, s_d);
      addv(0, 56'd0, 64'd0, 1, 1, 1, 0, 0,  s_pa, s_d);
      addv(0, 56'd0, 64'd0, 0, 1, 0, 1, 0,  s_pa, s_d);
      addv(0, 56'd0, 64'd0, 0, 1, 0, 0, 1,  56'd0, 64'd0);
      // fill with no grant: fifth push is dropped
      addv(1, pk(1), dk(1), 0, 1, 0, 0, 1,  56'd0, 64'd0);
      addv(1, pk(2), dk(2), 0, 1, 1, 0, 0,  pk(1), dk(1));
      addv(1, pk(3), dk(3), 0, 1, 1, 0, 0,  pk(1), dk(1));
      addv(1, pk(4), dk(4), 0, 1, 1, 0, 0,  pk(1), dk(1));
      addv(1, pk(5), dk(5), 0, 0, 1, 0, 0,  pk(1), dk(1));
      // grant head while full, push during the tag cycle is still refused
      addv(0, 56'd0, 64'd0, 1, 0, 1, 0, 0,  pk(1), dk(1));
      addv(1, pk(6), dk(6), 0, 0, 0, 1, 0,  pk(1), dk(1));
      addv(0, 56'd0, 64'd0, 1, 1, 1, 0, 0,  pk(2), dk(2));
      addv(0, 56'd0, 64'd0, 0, 1, 0, 1, 0,  pk(2), dk(2));
      addv(0, 56'd0, 64'd0, 1, 1, 1, 0, 0,  pk(3), dk(3));
      addv(0, 56'd0, 64'd0, 0, 1, 0, 1, 0,  pk(3), dk(3));
      addv(0, 56'd0, 64'd0, 1, 1, 1, 0, 0,  pk(4), dk(4));
      addv(0, 56'd0, 64'd0, 0, 1, 0, 1, 0,  pk(4), dk(4));
      addv(0, 56'd0, 64'd0, 0, 1, 0, 0, 1,  56'd0, 64'd0);

      // ---- reset values ----
      rst_ni = 1'b0; valid = 1'b0; req_in = '0; po = 12'h238;
      paddr = 56'd0; data = 64'd0; be = 8'd0; size = 2'd0;
      #3;
      chk("rst.ready", 64'(ready_o), 64'd1);
      chk("rst.empty", 64'(empty_o), 64'd1);
      chk("rst.match", 64'(match_o), 64'd0);
      chk("rst.req",   64'(req_out.data_req), 64'd0);
      chk("rst.tv",    64'(req_out.tag_valid), 64'd0);
      chk("rst.idx",   64'(req_out.address_index), 64'd0);
      chk("rst.tag",   64'(req_out.address_tag), 64'd0);
      chk("rst.wdata", req_out.data_wdata, 64'd0);
      chk("rst.be",    64'(req_out.data_be), 64'd0);
      chk("rst.kill",  64'(req_out.kill_req), 64'd0);
      chk("rst.ovf",   64'(dut.u_chk.overflow_seen_q), 64'd0);
      do_reset();

      // ---- table ----
      foreach (vt[i]) begin
         valid = vt[i].v; paddr = vt[i].pa; data = vt[i].d;
         be = 8'h0F; size = 2'd2; req_in.data_gnt = vt[i].g;
         #1;
         chk($sformatf("vec%0d.ready", i), 64'(ready_o), 64'(vt[i].e_rdy));
         chk($sformatf("vec%0d.req", i),   64'(req_out.data_req), 64'(vt[i].e_req));
         chk($sformatf("vec%0d.tv", i),    64'(req_out.tag_valid), 64'(vt[i].e_tv));
         chk($sformatf("vec%0d.empty", i), 64'(empty_o), 64'(vt[i].e_emp));
         if (vt[i].e_req) begin
            chk($sformatf("vec%0d.idx", i),   64'(req_out.address_index), 64'(vt[i].e_pa[11:0]));
            chk($sformatf("vec%0d.wdata", i), req_out.data_wdata, vt[i].e_d);
            chk($sformatf("vec%0d.be", i),    64'(req_out.data_be), 64'h0F);
            chk($sformatf("vec%0d.size", i),  64'(req_out.data_size), 64'd2);
         end
         if (vt[i].e_tv) begin
            chk($sformatf("vec%0d.tag", i), 64'(req_out.address_tag), 64'(vt[i].e_pa[55:12]));
         end
         @(posedge clk); #1;
      end
      chk("fill.overflow_flag", 64'(dut.u_chk.overflow_seen_q), 64'd1);

      // ---- offset check ----
      do_reset();
      mcycle("offs.push", 1'b1, mk(56'h1238, 64'h55, 8'hFF, 2'd3), 1'b0, 12'h000);
      valid = 1'b0; po = 12'h23C; #1;
      chk("offs.23C", 64'(match_o), 64'(OFFS_EN));
      po = 12'h240; #1;
      chk("offs.240", 64'(match_o), 64'd0);
      @(posedge clk); #1;

      // ---- wrap-around: 10 stores with grant always high ----
      do_reset();
      pushed = 0; ntag = 0; last_tag = -1;
      for (int c = 0; c < 26; c++) begin
         if (req_out.tag_valid) begin
            ntag++;
            last_tag = c;
         end
         e = mk(pk(20 + pushed), dk(20 + pushed), 8'(8'h01 << (pushed % 8)), 2'(pushed));
         if (pushed < 10) begin
            if (mq.size() != DEPTH) pushed++;
            mcycle($sformatf("wrap%0d", c), 1'b1, e, 1'b1, 12'h000);
         end else begin
            mcycle($sformatf("wrap%0d", c), 1'b0, e, 1'b1, 12'h000);
         end
      end
      chk("wrap.tags", 64'(ntag), 64'd10);
      chk("wrap.last_tag_cycle", 64'(last_tag), 64'd20);

      // ---- reset during the tag phase with 3 entries buffered ----
      do_reset();
      for (int k = 0; k < 3; k++)
         mcycle("mid.push", 1'b1, mk(pk(40 + k), dk(40 + k), 8'hF0, 2'd1), 1'b0, pk(40)[11:0]);
      mcycle("mid.gnt", 1'b0, mk(56'd0, 64'd0, 8'd0, 2'd0), 1'b1, pk(40)[11:0]);
      chk("mid.in_tag_phase", 64'(req_out.tag_valid), 64'd1);
      #1 rst_ni = 1'b0;
      #1;
      chk("mid.ready", 64'(ready_o), 64'd1);
      chk("mid.empty", 64'(empty_o), 64'd1);
      chk("mid.req",   64'(req_out.data_req), 64'd0);
      chk("mid.tv",    64'(req_out.tag_valid), 64'd0);
      chk("mid.tag",   64'(req_out.address_tag), 64'd0);
      chk("mid.match", 64'(match_o), 64'd0);
      mq.delete(); m_sent = 1'b0;
      @(negedge clk); rst_ni = 1'b1;
      @(posedge clk); #1;
      mcycle("mid.after", 1'b0, mk(56'd0, 64'd0, 8'd0, 2'd0), 1'b0, pk(41)[11:0]);

      // ---- randomized traffic against the queue model ----
      do_reset();
      for (int c = 0; c < 400; c++) begin
         logic [11:0] off;
         if (mq.size() > 0 && $urandom_range(0, 1) == 1)
            off = mq[$urandom_range(0, mq.size() - 1)].paddr[11:0] ^ 12'($urandom_range(0, 7));
         else
            off = 12'($urandom);
         e = mk({$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), 2'($urandom));
         mcycle($sformatf("rnd%0d", c), 1'($urandom_range(0, 1)), e,
                ($urandom_range(0, 9) < 6), off);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/commit_store_buffer.md
# commit_store_buffer

Queue of committed stores that sits directly upstream of the non-blocking L1 data cache and drains into its store request port (port 2). Commit pushes architecturally final stores. The buffer replays them one at a time into the cache using the index-then-tag two-phase request. It also reports whether any pending store overlaps a load's page offset, so the load unit can stall.

## Interface
Parameters:
- `DEPTH`, default 4: entry count; power of two, minimum 2.
- `INDEX_WIDTH`, default 12: cache index width, equal to `DCACHE_INDEX_WIDTH`.
- `TAG_WIDTH`, default 44: cache tag width, equal to `DCACHE_TAG_WIDTH`.

Ports (one clock; reset is asynchronous, active-low):
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous active-low reset
- `valid_i`  in  1  commit push strobe
- `ready_o`  out  1  buffer can accept a push
- `paddr_i`  in  56  physical address of the store
- `data_i`  in  64  store data, already byte-aligned
- `be_i`  in  8  byte enables
- `data_size_i`  in  2  log2 of the access size
- `req_port_i`  in  `dcache_req_o_t`  cache response; fields used: `data_gnt` (others ignored)
- `req_port_o`  out  `dcache_req_i_t`  cache request; fields used: `address_index`, `address_tag`, `data_wdata`, `data_be`, `data_size`, `data_req`, `data_we`, `kill_req`, `tag_valid`
- `page_offset_i`  in  12  load page offset to check
- `page_offset_matches_o`  out  1  a pending store overlaps the load's doubleword
- `empty_o`  out  1  no store pending or in flight

## Operation
- Storage: `DEPTH` entries of {paddr, data, be, size}.
- Pointers: `rd_ptr` and `wr_ptr` are `$clog2(DEPTH)` bits and wrap naturally. `count` is `$clog2(DEPTH)+1` bits.
- `ready_o` = (`count` != `DEPTH`), computed from the registered count. A same-cycle pop does not make room for a push.
- Push when `valid_i && ready_o`: write the entry at `wr_ptr`, increment `wr_ptr`. `valid_i` while `!ready_o` is a protocol error: the push is ignored and an assertion fires.
- Drain FSM, one store in flight:
  - IDLE:
    - If `count` != 0, drive `data_req`=1 with `address_index`=head `paddr[INDEX_WIDTH-1:0]`, `data_wdata`, `data_be`, `data_size` from the head entry.
    - On `data_gnt`=1, go to SEND_TAG; otherwise hold the request stable.
  - SEND_TAG:
    - Drive `tag_valid`=1 and `address_tag`=head `paddr[INDEX_WIDTH+TAG_WIDTH-1:INDEX_WIDTH]`, with `data_req`=0.
    - Pop the head (increment `rd_ptr`) and return to IDLE.
- Constants: `data_we`=1 and `kill_req`=0 at all times. `data_rvalid` and `data_rdata` are ignored.
- `count` update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged when push and pop happen in the same cycle.
- `empty_o` = (`count` == 0) && (state == IDLE).

## Timing
- Reset values:
  - `ready_o`=1, `empty_o`=1, `page_offset_matches_o`=0.
  - All `req_port_o` fields 0.
  - Pointers and `count` 0; state IDLE.
- Latency:
  - A push accepted in cycle t raises `data_req` in cycle t+1 when the buffer was empty.
  - Grant in cycle g → tag in g+1 → next `data_req` no earlier than g+2.
  - Peak drain rate is one store per 2 cycles.
- Full with simultaneous pop: `ready_o` stays 0 that cycle and rises the next cycle.
- Reset asserted mid-operation: all state clears immediately, including the in-flight store; buffered stores are discarded.
- `page_offset_matches_o` is combinational from `page_offset_i` and the registered entries.

## Configuration
- Macro: `COMMIT_SB_OFFSET_CHECK_EN`.
- Defined:
  - `page_offset_matches_o` = OR over all occupied entries (including the head while in flight) of (`paddr[11:3]` == `page_offset_i[11:3]`).
  - Unoccupied slots never match.
- Undefined:
  - No comparators are built; `page_offset_matches_o` is tied 0.
  - The load unit then relies on `empty_o` for ordering.

## Test plan
- Single store: after reset, push paddr=0x8000_1238, data=0xDEAD_BEEF, be=0x0F, size=2; hold `data_gnt`=0 for 3 cycles, then 1.
  → `data_req` held with index 0x238 for all 4 cycles; next cycle `tag_valid`=1 with tag 0x80001; `empty_o` rises one cycle later.
- Fill: `data_gnt`=0, push 5 stores.
  → `ready_o` falls after the 4th push; 5th push ignored and assertion flagged; count=4.
- Full plus simultaneous push and pop: full buffer, grant the head, then push in the SEND_TAG cycle.
  → Push ignored because `ready_o`=0; `ready_o`=1 on the next cycle; count=3.
- Wrap-around: 10 pushes and drains with `data_gnt` always 1.
  → Stores appear in order with correct data across the pointer wrap; 2 cycles per store.
- Offset check (macro defined): pending store at 0x1238; `page_offset_i`=0x23C → match=1; 0x240 → 0. With the macro undefined, the output is always 0.
- Reset mid-flight: assert `rst_ni`=0 during SEND_TAG with 3 entries buffered.
  → All outputs return to reset values asynchronously; `empty_o`=1 after release.
